mmio_byte_master: RTL and testbench

CPU-side initiator for the byte-wide memory-mapped I/O bus served by the timer and other peripherals.
- Accepts one byte, half or word load/store request at a time from the core's memory stage.
- Serialises the request into consecutive single-byte bus accesses, little-endian.
- For loads, collects the returned bytes, sign- or zero-extends them and returns one 32-bit response.

---
 rtl/mmio_pkg.sv | 51 +++++
 rtl/mmio_load_extend.sv | 26 ++
 rtl/mmio_byte_master.sv | 215 +++++++++++++++++++++
 tb/tb_mmio_byte_master.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared definitions for the byte-wide memory-mapped I/O bus.
// Holds the request size encodings, the bus master FSM states, the default
// responder read latency and the I/O base addresses that the peripherals use.
// It also holds small helpers for picking byte lanes out of a word.
package mmio_pkg;

  // Width of the I/O byte address.
  localparam int IO_ADDR_WIDTH        = 17;
  // Cycles from an en_out cycle until the responder's read byte is valid.
  localparam int DEFAULT_READ_LATENCY = 1;

  // Peripheral base addresses on the I/O bus.
  localparam logic [16:0] IO_TIMER_BASE = 17'h00000;
  localparam logic [16:0] IO_TIMER_CMP  = 17'h00004;

  // Request size encodings. A size of 2'd3 is also treated as a word.
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } mmio_state_e;

  // Index of the last byte of a request (N-1).
  function automatic logic [1:0] size_last_idx(input logic [1:0] size);
    logic [1:0] idx;
    case (size)
      SZ_BYTE: idx = 2'd0;
      SZ_HALF: idx = 2'd1;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

  // Little-endian byte lane idx of a 32-bit word.
  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/mmio_load_extend.sv
// Combinational size and sign extension of an assembled load value.
// Ports:
//   raw   - assembled bytes, right-justified
//   size  - request size (byte / half / word)
//   sign  - 1 = sign-extend, 0 = zero-extend
//   ext   - 32-bit extended result
module mmio_load_extend
  import mmio_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  size,
  input  logic        sign,
  output logic [31:0] ext
);

  // Select the extension from the top valid bit of the requested size
  always_comb begin
    ext = raw;
    case (size)
      SZ_BYTE: ext = {{24{sign & raw[7]}}, raw[7:0]};
      SZ_HALF: ext = {{16{sign & raw[15]}}, raw[15:0]};
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/mmio_byte_master.sv
// CPU-side initiator for the byte-wide MMIO bus.
// It takes one byte, half or word load/store request at a time. The request is
// issued as consecutive single-byte accesses, lowest address first. For loads,
// the returned bytes are assembled and extended into one 32-bit response.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   req_*               - core request (valid/ready handshake)
//   resp_valid/rdata    - one-cycle completion pulse and load data
//   en_out, r_nw_out,
//   a_out, d_out        - bus access strobe, direction, address, write data
//   d_in                - bus read data, valid READ_LATENCY cycles after en_out
module mmio_byte_master
  import mmio_pkg::*;
#(
  parameter int ADDR_WIDTH   = IO_ADDR_WIDTH,
  parameter int READ_LATENCY = DEFAULT_READ_LATENCY
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_sign,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  en_out,
  output logic                  r_nw_out,
  output logic [ADDR_WIDTH-1:0] a_out,
  output logic [7:0]            d_out,
  input  logic [7:0]            d_in
);

  localparam logic [2:0] LAT3 = 3'(READ_LATENCY);

  mmio_state_e           state_r, state_s;
  logic                  we_r, we_s;
  logic [ADDR_WIDTH-1:0] base_r, base_s;
  logic [1:0]            last_r, last_s;
  logic [1:0]            size_r, size_s;
  logic                  sign_r, sign_s;
  logic [31:0]           wdata_r, wdata_s;
  // Cycles since the first issue cycle. Byte i is issued at count i.
  // It is sampled at count i+READ_LATENCY.
  logic [2:0]            cyc_r, cyc_s;
  logic [31:0]           asm_r, asm_s;

  logic                  req_ready_s, resp_valid_s, en_s, r_nw_s;
  logic [31:0]           resp_rdata_s;
  logic [ADDR_WIDTH-1:0] a_s;
  logic [7:0]            d_s;

  logic                  samp_ok_s;
  logic [2:0]            samp_idx_s;
  logic [1:0]            nxt_idx_s;
  logic [31:0]           asm_merged_s;
  logic [31:0]           ext_s;

  // Decide whether this cycle is a scheduled read-data sample, and for which byte
  always_comb begin
    samp_idx_s = cyc_r - LAT3;
    if (!we_r && (state_r == ISSUE || state_r == DRAIN) && cyc_r >= LAT3 &&
        samp_idx_s <= {1'b0, last_r}) begin
      samp_ok_s = 1'b1;
    end else begin
      samp_ok_s = 1'b0;
    end
  end

  // Insert the sampled byte into its lane of the assembly register
  always_comb begin
    asm_merged_s = asm_r;
    if (samp_ok_s) begin
      case (samp_idx_s[1:0])
        2'd0:    asm_merged_s[7:0]   = d_in;
        2'd1:    asm_merged_s[15:8]  = d_in;
        2'd2:    asm_merged_s[23:16] = d_in;
        default: asm_merged_s[31:24] = d_in;
      endcase
    end else begin
      asm_merged_s = asm_r;
    end
  end

  // The extension sees the merged value so that the final byte is included
  mmio_load_extend u_extend (
    .raw  (asm_merged_s),
    .size (size_r),
    .sign (sign_r),
    .ext  (ext_s)
  );

  assign nxt_idx_s = cyc_r[1:0] + 2'd1;

  // Next-state and next-output logic. All outputs are registered from these values.
  always_comb begin
    state_s      = state_r;
    we_s         = we_r;
    base_s       = base_r;
    last_s       = last_r;
    size_s       = size_r;
    sign_s       = sign_r;
    wdata_s      = wdata_r;
    cyc_s        = cyc_r;
    asm_s        = asm_r;
    req_ready_s  = 1'b0;
    resp_valid_s = 1'b0;
    resp_rdata_s = resp_rdata;
    en_s         = 1'b0;
    r_nw_s       = 1'b1;
    a_s          = a_out;
    d_s          = d_out;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          state_s = ISSUE;
          we_s    = req_we;
          base_s  = req_addr;
          last_s  = size_last_idx(req_size);
          size_s  = req_size;
          sign_s  = req_sign;
          wdata_s = req_wdata;
          cyc_s   = 3'd0;
          asm_s   = 32'd0;
          en_s    = 1'b1;
          r_nw_s  = ~req_we;
          a_s     = req_addr;
          d_s     = req_we ? req_wdata[7:0] : 8'h00;
        end else begin
          req_ready_s = 1'b1;
        end
      end
      ISSUE: begin
        asm_s = asm_merged_s;
        cyc_s = cyc_r + 3'd1;
        if (cyc_r[1:0] == last_r) begin
          if (we_r) begin
            state_s      = RESP;
            resp_valid_s = 1'b1;
            resp_rdata_s = 32'd0;
          end else begin
            state_s = DRAIN;
          end
        end else begin
          en_s   = 1'b1;
          r_nw_s = ~we_r;
          // Address arithmetic truncates to ADDR_WIDTH, so the sequence wraps
          a_s    = base_r + ADDR_WIDTH'(nxt_idx_s);
          d_s    = we_r ? word_byte(wdata_r, nxt_idx_s) : 8'h00;
        end
      end
      DRAIN: begin
        asm_s = asm_merged_s;
        cyc_s = cyc_r + 3'd1;
        if (samp_ok_s && samp_idx_s[1:0] == last_r) begin
          state_s      = RESP;
          resp_valid_s = 1'b1;
          resp_rdata_s = ext_s;
        end else begin
          state_s = DRAIN;
        end
      end
      RESP: begin
        state_s     = IDLE;
        req_ready_s = 1'b1;
      end
      default: begin
        state_s     = IDLE;
        req_ready_s = 1'b1;
      end
    endcase
  end

  // State, request and output registers. Reset overrides any request in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      we_r       <= 1'b0;
      base_r     <= '0;
      last_r     <= 2'd0;
      size_r     <= 2'd0;
      sign_r     <= 1'b0;
      wdata_r    <= 32'd0;
      cyc_r      <= 3'd0;
      asm_r      <= 32'd0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      en_out     <= 1'b0;
      r_nw_out   <= 1'b1;
      a_out      <= '0;
      d_out      <= 8'h00;
    end else begin
      state_r    <= state_s;
      we_r       <= we_s;
      base_r     <= base_s;
      last_r     <= last_s;
      size_r     <= size_s;
      sign_r     <= sign_s;
      wdata_r    <= wdata_s;
      cyc_r      <= cyc_s;
      asm_r      <= asm_s;
      req_ready  <= req_ready_s;
      resp_valid <= resp_valid_s;
      resp_rdata <= resp_rdata_s;
      en_out     <= en_s;
      r_nw_out   <= r_nw_s;
      a_out      <= a_s;
      d_out      <= d_s;
    end
  end

endmodule

// File: tb/tb_mmio_byte_master.sv
// Self-checking bench for mmio_byte_master.
// Two instances are used, one with READ_LATENCY=1 and one with READ_LATENCY=3.
// Only one instance, chosen by sel, receives requests at a time.
// A responder memory returns read bytes with each instance's latency.
// A per-cycle monitor compares the active instance against a transaction-level model.
module tb_mmio_byte_master;

  logic        clk, rst;
  logic        sel;
  logic        req_valid, req_we, req_sign;
  logic [16:0] req_addr;
  logic [1:0]  req_size;
  logic [31:0] req_wdata;

  logic        rdy1, rv1, en1, rnw1, rdy3, rv3, en3, rnw3;
  logic [31:0] rd1, rd3;
  logic [16:0] a1, a3;
  logic [7:0]  d1, d3, din1, din3;

  logic [7:0]  mem [0:131071];
  logic [7:0]  garb;
  logic        pv1;
  logic [16:0] pa1;
  logic        pv3 [0:2];
  logic [16:0] pa3 [0:2];

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int resp_count = 0;

  mmio_byte_master #(.ADDR_WIDTH(17), .READ_LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid & ~sel), .req_ready(rdy1),
    .req_we(req_we), .req_addr(req_addr), .req_size(req_size), .req_sign(req_sign),
    .req_wdata(req_wdata), .resp_valid(rv1), .resp_rdata(rd1), .en_out(en1),
    .r_nw_out(rnw1), .a_out(a1), .d_out(d1), .d_in(din1));

  mmio_byte_master #(.ADDR_WIDTH(17), .READ_LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid & sel), .req_ready(rdy3),
    .req_we(req_we), .req_addr(req_addr), .req_size(req_size), .req_sign(req_sign),
    .req_wdata(req_wdata), .resp_valid(rv3), .resp_rdata(rd3), .en_out(en3),
    .r_nw_out(rnw3), .a_out(a3), .d_out(d3), .d_in(din3));

  // Outputs of the active instance
  logic        m_ready, m_rv, m_en, m_rnw;
  logic [31:0] m_rdata;
  logic [16:0] m_a;
  logic [7:0]  m_d;
  int          lat;
  assign m_ready = sel ? rdy3 : rdy1;
  assign m_rv    = sel ? rv3 : rv1;
  assign m_rdata = sel ? rd3 : rd1;
  assign m_en    = sel ? en3 : en1;
  assign m_rnw   = sel ? rnw3 : rnw1;
  assign m_a     = sel ? a3 : a1;
  assign m_d     = sel ? d3 : d1;
  assign lat     = sel ? 3 : 1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Responder: a read byte appears on d_in READ_LATENCY cycles after its en_out cycle
  always @(posedge clk) begin
    garb   <= 8'($urandom);
    pv1    <= en1 & rnw1;
    pa1    <= a1;
    pv3[0] <= en3 & rnw3;
    pa3[0] <= a3;
    pv3[1] <= pv3[0];
    pa3[1] <= pa3[0];
    pv3[2] <= pv3[1];
    pa3[2] <= pa3[1];
  end
  assign din1 = pv1 ? mem[pa1] : garb;
  assign din3 = pv3[2] ? mem[pa3[2]] : garb;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endfunction

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  // Load result from the spec rules: little-endian sum, then two's-complement reinterpretation
  function automatic logic [31:0] model_load(input logic [16:0] a, input int n, input logic sgn);
    longint v = 0;
    for (int i = 0; i < n; i++) v += longint'(mem[(int'(a) + i) % 131072]) << (8 * i);
    if (sgn && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
    return 32'(v);
  endfunction

  typedef struct packed {
    logic [16:0] a;
    logic        rnw;
    logic [7:0]  d;
  } bus_t;

  bus_t        bus_exp [int];
  logic [31:0] resp_exp [int];
  int          busy_until = -1;
  logic        rst_prev = 1'b0;

  // Monitor: checks every cycle against expectations scheduled at request acceptance
  always @(negedge clk) begin
    if (cyc >= 1) begin
      if (rst_prev) begin
        chk("rst_a_out", 32'(m_a), 32'd0);
        chk("rst_d_out", 32'(m_d), 32'd0);
        chk("rst_rdata", m_rdata, 32'd0);
      end
      chk("req_ready", 32'(m_ready), 32'(cyc > busy_until));
      chk("en_out", 32'(m_en), 32'(bus_exp.exists(cyc)));
      if (bus_exp.exists(cyc)) begin
        chk("a_out", 32'(m_a), 32'(bus_exp[cyc].a));
        chk("r_nw_out", 32'(m_rnw), 32'(bus_exp[cyc].rnw));
        chk("d_out", 32'(m_d), 32'(bus_exp[cyc].d));
      end else begin
        chk("r_nw_idle", 32'(m_rnw), 32'd1);
      end
      chk("resp_valid", 32'(m_rv), 32'(resp_exp.exists(cyc)));
      if (resp_exp.exists(cyc)) chk("resp_rdata", m_rdata, resp_exp[cyc]);
      if (m_rv) resp_count++;
      if (rst) begin
        for (int k = cyc + 1; k <= cyc + 10; k++) begin
          if (bus_exp.exists(k)) bus_exp.delete(k);
          if (resp_exp.exists(k)) resp_exp.delete(k);
        end
        busy_until = cyc;
      end else if (req_valid && m_ready) begin
        int n, rc;
        n = nbytes(req_size);
        for (int i = 0; i < n; i++)
          bus_exp[cyc + 1 + i] = '{a: 17'((int'(req_addr) + i) % 131072), rnw: ~req_we,
                                  d: req_we ? req_wdata[8*i +: 8] : 8'h00};
        rc = req_we ? cyc + n + 1 : cyc + n + lat + 1;
        resp_exp[rc] = req_we ? 32'd0 : model_load(req_addr, n, req_sign);
        busy_until = rc;
      end
    end
    rst_prev <= rst;
  end

  task automatic send(input logic we, input logic [16:0] addr, input logic [1:0] size,
                      input logic sgn, input logic [31:0] wd, output int acc);
    req_we = we; req_addr = addr; req_size = size; req_sign = sgn; req_wdata = wd;
    req_valid = 1'b1;
    acc = -1;
    for (int t = 0; t < 50 && acc < 0; t++) begin
      @(negedge clk);
      if (m_ready && !rst) acc = cyc;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    if (acc < 0) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_resp(output logic [31:0] rd, output int rc);
    rc = -1; rd = 32'hx;
    for (int t = 0; t < 50 && rc < 0; t++) begin
      @(negedge clk);
      if (m_rv) begin rd = m_rdata; rc = cyc; end
      @(posedge clk); #1;
    end
    if (rc < 0) chk("resp_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    logic        we;
    logic [16:0] addr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int acc, rc, k, n, cnt0;
    logic [31:0] rd;
    logic accepted, rv_seen;
    vec_t q [4];

    rst = 1'b1; sel = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 17'd0;
    req_size = 2'd0; req_sign = 1'b0; req_wdata = 32'd0;
    for (int i = 0; i < 131072; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h78; mem[1] = 8'h56; mem[2] = 8'h34; mem[3] = 8'h12;
    mem[17'h100] = 8'h85; mem[17'h200] = 8'h34; mem[17'h201] = 8'h92;
    mem[17'h1FFFE] = 8'hAA; mem[17'h1FFFF] = 8'hBB;

    vecs[0] = '{1'b1, 17'h00004, 2'd2, 1'b0, 32'h00000100, 32'h00000000};
    vecs[1] = '{1'b0, 17'h00000, 2'd2, 1'b0, 32'h0,        32'h12345678};
    vecs[2] = '{1'b0, 17'h00100, 2'd0, 1'b1, 32'h0,        32'hFFFFFF85};
    vecs[3] = '{1'b0, 17'h00100, 2'd0, 1'b0, 32'h0,        32'h00000085};
    vecs[4] = '{1'b0, 17'h00200, 2'd1, 1'b1, 32'h0,        32'hFFFF9234};
    vecs[5] = '{1'b0, 17'h00200, 2'd1, 1'b0, 32'h0,        32'h00009234};
    vecs[6] = '{1'b1, 17'h1FFFF, 2'd2, 1'b0, 32'hCAFEF00D, 32'h00000000};
    vecs[7] = '{1'b0, 17'h1FFFE, 2'd2, 1'b1, 32'h0,        32'h5678BBAA};
    vecs[8] = '{1'b0, 17'h00000, 2'd3, 1'b1, 32'h0,        32'h12345678};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Directed vectors on both latencies
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      for (int v = 0; v < 9; v++) begin
        send(vecs[v].we, vecs[v].addr, vecs[v].size, vecs[v].sgn, vecs[v].wdata, acc);
        wait_resp(rd, rc);
        n = nbytes(vecs[v].size);
        chk($sformatf("vec%0d_lat%0d_rdata", v, lat), rd, vecs[v].exp);
        chk($sformatf("vec%0d_lat%0d_latency", v, lat), 32'(rc - acc),
            32'(vecs[v].we ? n + 1 : n + lat + 1));
      end
    end

    // Reset during cycle 2 of a word store
    sel = 1'b0;
    cnt0 = resp_count;
    send(1'b1, 17'h00010, 2'd2, 1'b0, 32'hDEADBEEF, acc);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    rv_seen = 1'b0;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      if (t < 2) begin
        chk("abort_en_out", 32'(m_en), 32'd0);
        chk("abort_req_ready", 32'(m_ready), 32'd1);
        chk("abort_r_nw", 32'(m_rnw), 32'd1);
        chk("abort_a_out", 32'(m_a), 32'd0);
      end
      if (m_rv) rv_seen = 1'b1;
      @(posedge clk); #1;
    end
    chk("abort_no_resp", 32'(rv_seen), 32'd0);
    chk("abort_resp_count", 32'(resp_count - cnt0), 32'd0);

    // Back-to-back requests with req_valid held, latency 3
    sel = 1'b1;
    q[0] = '{1'b0, 17'h00000, 2'd2, 1'b0, 32'h0, 32'h0};
    q[1] = '{1'b1, 17'h00040, 2'd1, 1'b0, 32'h0000A55A, 32'h0};
    q[2] = '{1'b0, 17'h00100, 2'd0, 1'b1, 32'h0, 32'h0};
    q[3] = '{1'b0, 17'h1FFFE, 2'd2, 1'b0, 32'h0, 32'h0};
    cnt0 = resp_count;
    k = 0;
    req_we = q[0].we; req_addr = q[0].addr; req_size = q[0].size;
    req_sign = q[0].sgn; req_wdata = q[0].wdata; req_valid = 1'b1;
    for (int t = 0; t < 400 && k < 4; t++) begin
      @(negedge clk);
      accepted = m_ready;
      @(posedge clk); #1;
      if (accepted) begin
        k++;
        if (k < 4) begin
          req_we = q[k].we; req_addr = q[k].addr; req_size = q[k].size;
          req_sign = q[k].sgn; req_wdata = q[k].wdata;
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    chk("b2b_accepted", 32'(k), 32'd4);
    repeat (15) begin @(posedge clk); #1; end
    chk("b2b_resp_count", 32'(resp_count - cnt0), 32'd4);

    // Random requests on both latencies; the monitor model checks them
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      for (int r = 0; r < 60; r++) begin
        logic [16:0] ad;
        ad = ($urandom_range(0, 3) == 0) ? 17'(17'h1FFFC + $urandom_range(0, 3)) : 17'($urandom);
        send(1'($urandom), ad, 2'($urandom), 1'($urandom), $urandom, acc);
        wait_resp(rd, rc);
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
    end

    repeat (4) begin @(posedge clk); #1; end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
